// File: rtl/prng_keystream_ctrl_if.sv
// Keystream byte stream between the PRNG sequencer/packer and the cipher datapath.
// The master drives data and valid; the slave returns ready.
interface prng_keystream_ctrl_if;
   logic [7:0] ks_data;
   logic       ks_valid;
   logic       ks_ready;

   modport master (output ks_data, output ks_valid, input ks_ready);
   modport slave  (input ks_data, input ks_valid, output ks_ready);
endinterface

// File: rtl/prng_keystream_ctrl.sv
// Seeds the chaotic PRNG, skips warm-up iterations, packs 3 mantissas per iteration
// into a byte keystream and serves it through a show-ahead FIFO until the byte quota is met.
module prng_keystream_ctrl #(
   parameter int unsigned PRECISION  = 32,
   parameter int unsigned MANT_W     = 23,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [31:0]          cfg_nbytes,
   input  logic [15:0]          cfg_warmup,
   output logic                 prng_tvalid,
   input  logic                 prng_valid,
   input  logic [PRECISION-1:0] prng_r1,
   input  logic [PRECISION-1:0] prng_r2,
   input  logic [PRECISION-1:0] prng_r3,
   prng_keystream_ctrl_if.master ks,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int unsigned SAMPLE_W = 3 * MANT_W;
   localparam int unsigned SHREG_W  = SAMPLE_W + 7;
   localparam int unsigned BITS_W   = $clog2(SHREG_W + 1);
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_WARMUP,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [31:0]         nbytes_q;
   logic [15:0]         warm_q;
   logic [31:0]         produced_q;
   logic [SHREG_W-1:0]  shreg_q;
   logic [BITS_W-1:0]   bits_q;
   logic                overflow_q;
   logic                done_q, done_nxt;

   logic [7:0]          mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [CNT_W-1:0]    fifo_free;

   logic                load_session, flush;
   logic                quota_left, packer_idle, has_room, run_active;
   logic                accept, drop, push, pop, fifo_valid;
   logic [SAMPLE_W-1:0] sample;
   logic [SHREG_W-1:0]  sample_ext;
   logic                unused_hi;

   assign sample     = {prng_r1[MANT_W-1:0], prng_r2[MANT_W-1:0], prng_r3[MANT_W-1:0]};
   assign sample_ext = {sample, {(SHREG_W - SAMPLE_W){1'b0}}};
   assign unused_hi  = ^{prng_r1[PRECISION-1:MANT_W], prng_r2[PRECISION-1:MANT_W],
                         prng_r3[PRECISION-1:MANT_W]};

   // Worst case a sample plus 7 residue bits yields 9 bytes, hence the 9-entry room test.
   assign fifo_free   = CNT_W'(FIFO_DEPTH) - fifo_cnt;
   assign has_room    = fifo_free >= CNT_W'(9);
   assign packer_idle = bits_q < BITS_W'(8);
   assign quota_left  = produced_q < nbytes_q;
   assign run_active  = (state == S_RUN) && !abort && quota_left;
   assign accept      = run_active && prng_valid && packer_idle && has_room;
   assign drop        = run_active && prng_valid && !(packer_idle && has_room);
   assign push        = run_active && !packer_idle;
   assign fifo_valid  = fifo_cnt != '0;
   assign pop         = fifo_valid && ks.ks_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      done_nxt     = 1'b0;
      prng_tvalid  = 1'b0;
      load_session = 1'b0;
      flush        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load_session = 1'b1;
               state_nxt    = (cfg_nbytes == '0) ? S_DRAIN : S_SEED;
            end
         end
         S_SEED: begin
            prng_tvalid = 1'b1;
            state_nxt   = (warm_q != '0) ? S_WARMUP : S_RUN;
         end
         S_WARMUP: begin
            if (prng_valid && warm_q == 16'd1) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!quota_left) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!fifo_valid) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
         state_nxt   = S_IDLE;
         done_nxt    = 1'b0;
         prng_tvalid = 1'b0;
         flush       = 1'b1;
      end
   end

   // Residue is kept MSB-aligned; a new sample is OR-ed in directly below it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nbytes_q   <= '0;
         warm_q     <= '0;
         produced_q <= '0;
         shreg_q    <= '0;
         bits_q     <= '0;
         overflow_q <= 1'b0;
      end else if (load_session) begin
         nbytes_q   <= cfg_nbytes;
         warm_q     <= cfg_warmup;
         produced_q <= '0;
         shreg_q    <= '0;
         bits_q     <= '0;
         overflow_q <= 1'b0;
      end else if (flush || (state == S_RUN && !quota_left)) begin
         shreg_q <= '0;
         bits_q  <= '0;
      end else begin
         if (state == S_WARMUP && prng_valid) warm_q <= warm_q - 16'd1;
         if (accept) begin
            shreg_q <= shreg_q | (sample_ext >> bits_q);
            bits_q  <= bits_q + BITS_W'(SAMPLE_W);
         end else if (push) begin
            shreg_q    <= shreg_q << 8;
            bits_q     <= bits_q - BITS_W'(8);
            produced_q <= produced_q + 32'd1;
         end
         if (drop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg_q[SHREG_W-1 -: 8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign ks.ks_valid = fifo_valid;
   assign ks.ks_data  = fifo_valid ? mem[rd_ptr] : '0;
   assign busy        = state != S_IDLE;
   assign done        = done_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_prng_keystream_ctrl.sv
// Directed bench for prng_keystream_ctrl: a queue-based keystream model checked every
// cycle, plus hand-computed byte values and timing points for each scenario.
module tb_prng_keystream_ctrl;

   localparam int P_IDLE   = 0;
   localparam int P_SEED   = 1;
   localparam int P_WARMUP = 2;
   localparam int P_RUN    = 3;
   localparam int P_DRAIN  = 4;
   localparam int MANT     = 23;
   localparam int DEPTH    = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] cfg_nbytes = '0;
   logic [15:0] cfg_warmup = '0;
   logic        prng_valid = 1'b0;
   logic [31:0] r1 = '0, r2 = '0, r3 = '0;
   logic        ks_ready = 1'b0;
   logic        prng_tvalid, busy, done, overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   logic [7:0] got [$];

   prng_keystream_ctrl_if ks_if ();
   assign ks_if.ks_ready = ks_ready;

   prng_keystream_ctrl #(.PRECISION(32), .MANT_W(23), .FIFO_DEPTH(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .cfg_nbytes  (cfg_nbytes),
      .cfg_warmup  (cfg_warmup),
      .prng_tvalid (prng_tvalid),
      .prng_valid  (prng_valid),
      .prng_r1     (r1),
      .prng_r2     (r2),
      .prng_r3     (r3),
      .ks          (ks_if),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Model state: what the outputs must show after the most recent rising edge.
   int          m_phase = P_IDLE;
   int          m_warm  = 0;
   logic [31:0] m_nb    = '0;
   logic [31:0] m_prod  = '0;
   bit          m_bits [$];
   logic [7:0]  m_fifo [$];
   bit          m_ovf   = 1'b0;
   bit          m_done  = 1'b0;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_phase = P_IDLE; m_warm = 0; m_nb = '0; m_prod = '0;
         m_bits.delete(); m_fifo.delete(); m_ovf = 1'b0; m_done = 1'b0;
      end else begin
         automatic int   sz_pre = m_fifo.size();
         automatic bit   pop_now = (sz_pre != 0) && ks_ready;
         automatic logic [7:0] b;
         m_done = 1'b0;
         if (m_phase != P_IDLE && abort) begin
            m_fifo.delete(); m_bits.delete(); m_phase = P_IDLE;
         end else begin
            if (pop_now) void'(m_fifo.pop_front());
            case (m_phase)
               P_IDLE: if (start) begin
                  m_nb = cfg_nbytes; m_warm = int'(cfg_warmup); m_prod = '0;
                  m_bits.delete(); m_ovf = 1'b0;
                  m_phase = (cfg_nbytes == 0) ? P_DRAIN : P_SEED;
               end
               P_SEED: m_phase = (m_warm > 0) ? P_WARMUP : P_RUN;
               P_WARMUP: if (prng_valid) begin
                  m_warm--;
                  if (m_warm == 0) m_phase = P_RUN;
               end
               P_RUN: begin
                  if (m_prod == m_nb) begin
                     m_phase = P_DRAIN; m_bits.delete();
                  end else if (m_bits.size() >= 8) begin
                     b = '0;
                     for (int k = 0; k < 8; k++) b = {b[6:0], m_bits.pop_front()};
                     m_fifo.push_back(b);
                     m_prod++;
                     if (prng_valid) m_ovf = 1'b1;
                  end else if (prng_valid) begin
                     if (DEPTH - sz_pre >= 9) begin
                        for (int k = MANT - 1; k >= 0; k--) m_bits.push_back(r1[k]);
                        for (int k = MANT - 1; k >= 0; k--) m_bits.push_back(r2[k]);
                        for (int k = MANT - 1; k >= 0; k--) m_bits.push_back(r3[k]);
                     end else m_ovf = 1'b1;
                  end
               end
               P_DRAIN: if (sz_pre == 0) begin
                  m_done = 1'b1; m_phase = P_IDLE;
               end
               default: m_phase = P_IDLE;
            endcase
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      chk("cyc_ks_valid", 32'(ks_if.ks_valid), 32'(m_fifo.size() != 0));
      chk("cyc_ks_data", 32'(ks_if.ks_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
      chk("cyc_busy", 32'(busy), 32'(m_phase != P_IDLE));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_prng_tvalid", 32'(prng_tvalid), 32'(m_phase == P_SEED && !abort));
      if (ks_if.ks_valid && ks_ready) got.push_back(ks_if.ks_data);
      if (done) done_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      r1 = a; r2 = b; r3 = c; prng_valid = 1'b1;
      tick(1);
      prng_valid = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] nb, input logic [15:0] wu);
      cfg_nbytes = nb; cfg_warmup = wu; start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      automatic int base = done_cnt;
      for (int i = 0; i < bound && done_cnt == base; i++) tick(1);
      chk(name, 32'(done_cnt - base), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      automatic logic [7:0] exp2 [9] = '{8'h24, 8'h68, 8'hAD, 8'h95, 8'h0C,
                                         8'h84, 8'h55, 8'hE6, 8'hF6};
      automatic int base;

      tick(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ks_valid", 32'(ks_if.ks_valid), 32'd0);
      chk("rst_ks_data", 32'(ks_if.ks_data), 32'd0);
      reset_n = 1'b1;
      tick(1);

      // Warm-up 3, 9 bytes: hand-packed bytes from samples 4 and 5.
      ks_ready = 1'b1; got.delete();
      do_start(32'd9, 16'd3);
      chk("t2_tvalid_seed", 32'(prng_tvalid), 32'd1);
      tick(1);
      chk("t2_tvalid_once", 32'(prng_tvalid), 32'd0);
      tick(1);
      for (int i = 0; i < 3; i++) begin
         send_sample(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADF00D);
         tick(3);
      end
      chk("t2_warmup_no_bytes", 32'(got.size()), 32'd0);
      send_sample(32'h3F123456, 32'h00654321, 32'h000ABCDE);
      tick(12);
      send_sample(32'h00600000, 32'h0, 32'h0);
      wait_done("t2_done", 40);
      chk("t2_busy_after_done", 32'(busy), 32'd0);
      chk("t2_nbytes", 32'(got.size()), 32'd9);
      for (int i = 0; i < 9 && i < got.size(); i++) chk($sformatf("t2_byte%0d", i), 32'(got[i]), 32'(exp2[i]));
      tick(2);

      // All-ones mantissas, no warm-up, 8 bytes of FF.
      got.delete();
      do_start(32'd8, 16'd0);
      tick(1);
      send_sample(32'h007FFFFF, 32'hFFFFFFFF, 32'h807FFFFF);
      wait_done("t3_done", 40);
      chk("t3_nbytes", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("t3_byte%0d", i), 32'(got[i]), 32'hFF);
      tick(2);

      // Stalled consumer: samples dropped, head byte held, then full 64-byte stream.
      ks_ready = 1'b0; got.delete();
      do_start(32'd64, 16'd0);
      tick(1);
      base = done_cnt;
      for (int i = 0; i < 40 && done_cnt == base; i++) begin
         send_sample(32'h00ABCDEF ^ (32'(i) * 32'h01234567), 32'h13579BDF + 32'(i),
                     32'h2468ACE0 ^ (32'(i) << 3));
         tick(11);
         if (i == 3) begin
            chk("t4_overflow", 32'(overflow), 32'd1);
            chk("t4_ks_valid_held", 32'(ks_if.ks_valid), 32'd1);
            chk("t4_ks_data_held", 32'(ks_if.ks_data), 32'h57);
            ks_ready = 1'b1;
         end
      end
      for (int i = 0; i < 60 && done_cnt == base; i++) tick(1);
      chk("t4_done", 32'(done_cnt - base), 32'd1);
      chk("t4_nbytes", 32'(got.size()), 32'd64);
      chk("t4_first_byte", (got.size() != 0) ? 32'(got[0]) : 32'hFFFF, 32'h57);
      tick(2);

      // Zero-byte session: done two edges after start, no seed strobe.
      do_start(32'd0, 16'd5);
      chk("t5_no_tvalid", 32'(prng_tvalid), 32'd0);
      chk("t5_done_not_yet", 32'(done), 32'd0);
      tick(1);
      chk("t5_done_pulse", 32'(done), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      tick(1);
      chk("t5_done_single", 32'(done), 32'd0);
      tick(1);

      // Abort in RUN with 5 bytes queued, then restart.
      ks_ready = 1'b0;
      do_start(32'd100, 16'd0);
      tick(1);
      send_sample(32'h00111111, 32'h00222222, 32'h00333333);
      send_sample(32'h00444444, 32'h00555555, 32'h00666666);
      tick(4);
      chk("t6_overflow_set", 32'(overflow), 32'd1);
      chk("t6_ks_valid_pre", 32'(ks_if.ks_valid), 32'd1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t6_ks_valid_flushed", 32'(ks_if.ks_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      base = done_cnt;
      tick(5);
      chk("t6_no_done", 32'(done_cnt - base), 32'd0);
      chk("t6_overflow_kept", 32'(overflow), 32'd1);
      ks_ready = 1'b1;
      do_start(32'd9, 16'd0);
      chk("t6_tvalid_again", 32'(prng_tvalid), 32'd1);
      chk("t6_overflow_clear", 32'(overflow), 32'd0);
      tick(1);
      send_sample(32'h00123456, 32'h00654321, 32'h000FEDCB);
      tick(12);
      send_sample(32'h00777777, 32'h00888888, 32'h00999999);
      wait_done("t6_done", 40);
      tick(2);

      // Reset while running with bytes queued.
      ks_ready = 1'b0;
      do_start(32'd50, 16'd0);
      tick(1);
      send_sample(32'h00ABCDEF, 32'h00FEDCBA, 32'h00135790);
      tick(4);
      chk("t1_pre_valid", 32'(ks_if.ks_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t1_ks_valid", 32'(ks_if.ks_valid), 32'd0);
      chk("t1_ks_data", 32'(ks_if.ks_data), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_done", 32'(done), 32'd0);
      chk("t1_overflow", 32'(overflow), 32'd0);
      chk("t1_tvalid", 32'(prng_tvalid), 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
